tpumac_pipe: RTL and testbench

TPUMAC_PIPE -- requirements
Module: tpumac_pipe

---
 rtl/tpumac_pipe.sv | 104 ++++++++++
 tb/tb_tpumac_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpumac_pipe.sv
// Two-stage multiply-accumulate cell for a systolic array: S1 registers the
// lane-summed products, S2 accumulates (or preloads) into Cout with optional saturation.
module tpumac_pipe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int LANES   = 1,
  parameter int SAT     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             WrEn,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic        [LANES*BITS_AB-1:0]  Ain,
  input  logic        [LANES*BITS_AB-1:0]  Bin,
  input  logic signed [BITS_C-1:0]         Cin,
  output logic        [LANES*BITS_AB-1:0]  Aout,
  output logic        [LANES*BITS_AB-1:0]  Bout,
  output logic signed [BITS_C-1:0]         Cout,
  output logic                             out_valid,
  output logic                             ovf
);

  localparam int PW = 2*BITS_AB + $clog2(LANES) + 1;
  localparam int SW = ((BITS_C > PW) ? BITS_C : PW) + 1;
  localparam logic signed [BITS_C-1:0] CMAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] CMIN = {1'b1, {(BITS_C-1){1'b0}}};

  logic signed [PW-1:0]        psum_c;
  logic signed [2*BITS_AB-1:0] a_ext, b_ext, prod;

  logic                        s1_valid, s1_wren;
  logic signed [PW-1:0]        s1_psum;
  logic signed [BITS_C-1:0]    s1_cin;

  logic signed [SW-1:0]        sum_c;
  logic        [SW-BITS_C:0]   hi;
  logic                        range_ovf;
  logic signed [BITS_C-1:0]    acc_c;

  // Operands are widened to the product width so the low half of the
  // multiply is the exact signed product.
  always_comb begin
    psum_c = '0;
    a_ext  = '0;
    b_ext  = '0;
    prod   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_ext  = {{BITS_AB{Ain[i*BITS_AB + BITS_AB - 1]}}, Ain[i*BITS_AB +: BITS_AB]};
      b_ext  = {{BITS_AB{Bin[i*BITS_AB + BITS_AB - 1]}}, Bin[i*BITS_AB +: BITS_AB]};
      prod   = a_ext * b_ext;
      psum_c = psum_c + {{(PW-2*BITS_AB){prod[2*BITS_AB-1]}}, prod};
    end
  end

  // Out of range whenever the bits above the result sign are not a pure sign extension.
  always_comb begin
    sum_c     = {{(SW-BITS_C){Cout[BITS_C-1]}}, Cout}
              + {{(SW-PW){s1_psum[PW-1]}}, s1_psum};
    hi        = sum_c[SW-1:BITS_C-1];
    range_ovf = !((&hi) || !(|hi));
    if (range_ovf && (SAT != 0))
      acc_c = sum_c[SW-1] ? CMIN : CMAX;
    else
      acc_c = sum_c[BITS_C-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Aout      <= '0;
      Bout      <= '0;
      Cout      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      s1_valid  <= 1'b0;
      s1_wren   <= 1'b0;
      s1_psum   <= '0;
      s1_cin    <= '0;
    end else if (clr) begin
      Cout      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      s1_valid  <= 1'b0;
      s1_wren   <= 1'b0;
    end else if (en) begin
      Aout      <= Ain;
      Bout      <= Bin;
      s1_valid  <= in_valid;
      s1_wren   <= WrEn;
      s1_psum   <= psum_c;
      s1_cin    <= Cin;
      out_valid <= s1_valid | s1_wren;
      if (s1_wren) begin
        Cout <= s1_cin;
        ovf  <= 1'b0;
      end else if (s1_valid) begin
        Cout <= acc_c;
        if (range_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpumac_pipe.sv
// Bench for tpumac_pipe: a saturating and a wrapping 4-lane instance share
// stimulus and are checked every cycle against a transaction-level model.
module tb_tpumac_pipe;

  logic               clk = 1'b0;
  logic               rst, en, WrEn, clr, in_valid;
  logic        [31:0] Ain, Bin;
  logic signed [15:0] Cin;

  logic        [31:0] aout_s, bout_s, aout_w, bout_w;
  logic signed [15:0] cout_s, cout_w;
  logic               ov_s, ov_w, ovf_s, ovf_w;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .LANES(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr), .in_valid(in_valid),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .Aout(aout_s), .Bout(bout_s),
    .Cout(cout_s), .out_valid(ov_s), .ovf(ovf_s));

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .LANES(4), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr), .in_valid(in_valid),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .Aout(aout_w), .Bout(bout_w),
    .Cout(cout_w), .out_valid(ov_w), .ovf(ovf_w));

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: index 0 = saturating, 1 = wrapping.
  int          m_cout[2];
  bit          m_ovf[2];
  bit          m_ov[2];
  logic [31:0] m_aout = '0, m_bout = '0;
  bit          p_valid = 1'b0, p_wren = 1'b0;
  int          p_psum = 0, p_cin = 0;

  function automatic int dot(input logic [31:0] a, input logic [31:0] b);
    int  s = 0;
    byte sa, sb;
    for (int i = 0; i < 4; i++) begin
      sa = a[i*8 +: 8];
      sb = b[i*8 +: 8];
      s += int'(sa) * int'(sb);
    end
    return s;
  endfunction

  function automatic void acc(input int m);
    longint  s;
    shortint t;
    s = longint'(m_cout[m]) + longint'(p_psum);
    if (m == 0) begin
      if (s > 32767) begin m_cout[m] = 32767; m_ovf[m] = 1'b1; end
      else if (s < -32768) begin m_cout[m] = -32768; m_ovf[m] = 1'b1; end
      else m_cout[m] = int'(s);
    end else begin
      t = shortint'(s);
      if (longint'(t) != s) m_ovf[m] = 1'b1;
      m_cout[m] = int'(t);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin m_cout[m] = 0; m_ovf[m] = 1'b0; m_ov[m] = 1'b0; end
      m_aout = '0; m_bout = '0;
      p_valid = 1'b0; p_wren = 1'b0; p_psum = 0; p_cin = 0;
    end else if (clr) begin
      for (int m = 0; m < 2; m++) begin m_cout[m] = 0; m_ovf[m] = 1'b0; m_ov[m] = 1'b0; end
      p_valid = 1'b0; p_wren = 1'b0;
    end else if (en) begin
      for (int m = 0; m < 2; m++) begin
        m_ov[m] = p_valid || p_wren;
        if (p_wren) begin m_cout[m] = p_cin; m_ovf[m] = 1'b0; end
        else if (p_valid) acc(m);
      end
      p_valid = in_valid;
      p_wren  = WrEn;
      p_psum  = dot(Ain, Bin);
      p_cin   = int'(Cin);
      m_aout  = Ain;
      m_bout  = Bin;
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      check("cout_sat", int'(cout_s), m_cout[0]);
      check("cout_wrap", int'(cout_w), m_cout[1]);
      check("ovf_sat", ovf_s, m_ovf[0]);
      check("ovf_wrap", ovf_w, m_ovf[1]);
      check("ov_sat", ov_s, m_ov[0]);
      check("ov_wrap", ov_w, m_ov[1]);
      check("aout_sat", aout_s, m_aout);
      check("bout_sat", bout_s, m_bout);
      check("aout_wrap", aout_w, m_aout);
      check("bout_wrap", bout_w, m_bout);
    end
  end

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic idle;
    rst = 1'b0; en = 1'b1; WrEn = 1'b0; clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic load(input logic signed [15:0] c);
    idle(); WrEn = 1'b1; Cin = c; tick();
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b);
    idle(); in_valid = 1'b1; Ain = a; Bin = b; tick();
  endtask

  initial begin
    idle(); Ain = '0; Bin = '0; Cin = '0;
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_cout", int'(cout_s), 0);
    check("rst_ovf", ovf_s, 0);
    check("rst_ov", ov_s, 0);

    // Preload 100 then accumulate 3*-4
    load(16'sd100);
    op(32'h0000_0003, 32'h0000_00FC);
    check("load_cout", int'(cout_s), 100);
    check("load_ov", ov_s, 1);
    idle(); tick();
    check("acc_cout", int'(cout_s), 88);
    check("acc_ov", ov_s, 1);
    tick();
    check("ov_drop", ov_s, 0);

    // Four-lane dot product
    load(16'sd0);
    op(32'h0403_0201, 32'h0807_0605);
    check("aout_fwd", aout_s, 32'h0403_0201);
    check("bout_fwd", bout_s, 32'h0807_0605);
    idle(); tick();
    check("dot4", int'(cout_s), 70);

    // Positive overflow
    load(16'sd32760);
    op(32'h0000_007F, 32'h0000_007F);
    idle(); tick();
    check("sat_hi", int'(cout_s), 32767);
    check("sat_hi_ovf", ovf_s, 1);
    check("wrap_hi", int'(cout_w), -16647);
    check("wrap_hi_ovf", ovf_w, 1);
    tick();
    check("ovf_sticky", ovf_s, 1);
    load(16'sd0);
    idle(); tick();
    check("ovf_clr_load", ovf_s, 0);
    check("ovf_clr_load_w", ovf_w, 0);

    // Negative overflow across all four lanes
    load(-16'sd32760);
    op(32'h7F7F_7F7F, 32'h8080_8080);
    idle(); tick();
    check("sat_lo", int'(cout_s), -32768);
    check("wrap_lo", int'(cout_w), -32248);

    // Stall mid-stream
    load(16'sd0);
    op(32'd10, 32'd10);
    op(32'd5, 32'd5);
    check("pre_stall", int'(cout_s), 100);
    for (int i = 0; i < 3; i++) begin
      idle(); en = 1'b0; in_valid = 1'b1; Ain = 32'd99; Bin = 32'd99; tick();
      check("stall_cout", int'(cout_s), 100);
      check("stall_aout", aout_s, 32'd5);
    end
    op(32'd2, 32'd3);
    check("post_stall", int'(cout_s), 125);
    idle(); tick();
    check("stall_final", int'(cout_s), 131);

    // clr with valid data in S1 and en low
    load(16'sd32700);
    op(32'h0000_007F, 32'h0000_007F);
    op(32'd7, 32'd7);
    check("pre_clr_ovf", ovf_s, 1);
    idle(); clr = 1'b1; en = 1'b0; in_valid = 1'b1; Ain = 32'd9; Bin = 32'd9; tick();
    check("clr_cout", int'(cout_s), 0);
    check("clr_ovf", ovf_s, 0);
    check("clr_ov", ov_s, 0);
    idle(); tick();
    check("clr_discard", int'(cout_s), 0);
    check("clr_discard_ov", ov_s, 0);

    // Reset mid-operation
    load(16'sd1000);
    op(32'd3, 32'd3);
    idle(); rst = 1'b1; en = 1'b0; in_valid = 1'b1; tick();
    check("rst_mid_cout", int'(cout_s), 0);
    check("rst_mid_aout", aout_s, 0);
    idle(); tick();
    check("rst_discard", int'(cout_s), 0);

    // Mixed traffic, model-checked
    for (int i = 0; i < 60; i++) begin
      idle();
      en       = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 1);
      WrEn     = ($urandom_range(0, 5) == 0);
      clr      = ($urandom_range(0, 19) == 0);
      Cin      = 16'($urandom);
      Ain      = $urandom;
      Bin      = $urandom;
      tick();
    end
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
